// File: rtl/aux_resume_button.sv
// Front-panel resume button: two-flop synchronizer, counter debounce and a
// press/auto-repeat FSM that emits single-cycle resume strobes.
module aux_resume_button #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16,
  parameter int CNT_WIDTH       = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic resume,
  output logic btn_level
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_REPEAT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DB_LAST     = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);

  logic                 btn_m;
  logic                 btn_s;
  logic [CNT_WIDTH-1:0] db_cnt;
  logic [CNT_WIDTH-1:0] rep_cnt;
  logic                 mismatch;
  logic                 db_done;
  logic                 level_rise;
  logic                 level_fall;
  state_t               state;
  state_t               state_next;
  logic                 pulse_next;
  logic                 rep_clr;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, which is what makes btn_m->btn_s a chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
    end
  end

  assign mismatch   = (btn_s != btn_level);
  assign db_done    = mismatch && (db_cnt == DB_LAST);
  assign level_rise = db_done && !btn_level;
  assign level_fall = db_done && btn_level;

  // Any agreeing sample restarts the count, so a bounce can never accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (!mismatch || db_done) begin
      db_cnt    <= '0;
      btn_level <= btn_level ^ db_done;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: defaulting every comb output before the case keeps paths that do
  // not assign it from inferring a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (level_rise) state_next = ST_HELD;
      ST_HELD: begin
        if (level_fall)                                  state_next = ST_IDLE;
        else if (REPEAT_EN && (rep_cnt == DELAY_LAST))   state_next = ST_REPEAT;
      end
      ST_REPEAT: if (level_fall) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // A release accepted on the same edge as a due repeat suppresses the repeat.
  always_comb begin
    pulse_next = 1'b0;
    rep_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        pulse_next = level_rise;
        rep_clr    = level_rise;
      end
      ST_HELD: begin
        pulse_next = !level_fall && REPEAT_EN && (rep_cnt == DELAY_LAST);
        rep_clr    = pulse_next;
      end
      ST_REPEAT: begin
        pulse_next = !level_fall && (rep_cnt == PERIOD_LAST);
        rep_clr    = pulse_next;
      end
      default: begin
        pulse_next = 1'b0;
        rep_clr    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
      resume  <= 1'b0;
    end else begin
      resume <= pulse_next;
      if (rep_clr || !REPEAT_EN || (state_next == ST_IDLE)) rep_cnt <= '0;
      else                                                   rep_cnt <= rep_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aux_resume_button.sv
// Directed bench for aux_resume_button: one plain instance and one with
// auto-repeat, both fed from the same button.
module tb_aux_resume_button;

  logic clk;
  logic rst_n;
  logic btn;
  logic resume0, btn_level0;
  logic resume1, btn_level1;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_idx = 0;
  int p0[$];
  int p1[$];
  int lvl0[$];

  aux_resume_button #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .CNT_WIDTH(24)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .btn(btn), .resume(resume0), .btn_level(btn_level0)
  );

  aux_resume_button #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .CNT_WIDTH(24)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .btn(btn), .resume(resume1), .btn_level(btn_level1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_phase();
    edge_idx = 0;
    p0.delete();
    p1.delete();
    lvl0.delete();
  endtask

  // Advance n edges, logging which edge index each strobe and level appears on.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (resume0) p0.push_back(edge_idx);
      if (resume1) p1.push_back(edge_idx);
      lvl0.push_back(int'(btn_level0));
      edge_idx++;
    end
  endtask

  initial begin
    int exp_rep[8];
    exp_rep = '{5, 13, 17, 21, 25, 29, 33, 37};
    btn   = 1'b0;
    rst_n = 1'b0;
    #3;
    check("reset_resume0", int'(resume0), 0);
    check("reset_level0",  int'(btn_level0), 0);
    check("reset_resume1", int'(resume1), 0);
    check("reset_level1",  int'(btn_level1), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Clean press
    start_phase();
    btn = 1'b1;
    watch(20);
    check("clean_pulses",    p0.size(), 1);
    check("clean_pulse_edge", (p0.size() > 0) ? p0[0] : -1, 5);
    check("clean_level_e4",  lvl0[4], 0);
    check("clean_level_e5",  lvl0[5], 1);
    check("clean_level_e19", lvl0[19], 1);
    check("clean_rep_first", (p1.size() > 0) ? p1[0] : -1, 5);

    // Release
    start_phase();
    btn = 1'b0;
    watch(10);
    check("release_level_e4", lvl0[4], 1);
    check("release_level_e5", lvl0[5], 0);
    check("release_pulses",   p0.size(), 0);

    // Glitch
    start_phase();
    btn = 1'b1;
    watch(3);
    btn = 1'b0;
    watch(10);
    check("glitch_pulses0", p0.size(), 0);
    check("glitch_pulses1", p1.size(), 0);
    check("glitch_level",   lvl0.sum(), 0);
    check("glitch_db_cnt",  int'(dut0.db_cnt), 0);

    // Bounce
    start_phase();
    for (int k = 0; k < 3; k++) begin
      btn = 1'b1;
      watch(2);
      btn = 1'b0;
      watch(2);
    end
    check("bounce_toggle_pulses", p0.size() + p1.size(), 0);
    check("bounce_toggle_level",  lvl0.sum(), 0);
    start_phase();
    btn = 1'b1;
    watch(8);
    check("bounce_pulses",    p0.size(), 1);
    check("bounce_pulse_edge", (p0.size() > 0) ? p0[0] : -1, 5);
    btn = 1'b0;
    watch(10);

    // Auto-repeat: press pulse P at edge 5, held to P+30, then released
    start_phase();
    btn = 1'b1;
    watch(36);
    btn = 1'b0;
    watch(12);
    check("repeat_count", p1.size(), 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("repeat_edge%0d", k), (k < p1.size()) ? p1[k] : -1, exp_rep[k]);
    check("repeat_plain_pulses", p0.size(), 1);
    check("repeat_level_e40",    lvl0[40], 1);
    check("repeat_level_e41",    lvl0[41], 0);

    // Reset mid-press, landing while dut1 is driving a repeat strobe
    start_phase();
    btn = 1'b1;
    watch(14);
    check("pre_reset_strobe", int'(resume1), 1);
    rst_n = 1'b0;
    #2;
    check("async_resume1", int'(resume1), 0);
    check("async_level0",  int'(btn_level0), 0);
    check("async_level1",  int'(btn_level1), 0);
    tick();
    tick();
    rst_n = 1'b1;
    start_phase();
    watch(12);
    check("rst_pulses0",     p0.size(), 1);
    check("rst_pulse_edge0", (p0.size() > 0) ? p0[0] : -1, 5);
    check("rst_pulse_edge1", (p1.size() > 0) ? p1[0] : -1, 5);
    check("rst_level_e4",    lvl0[4], 0);
    check("rst_level_e5",    lvl0[5], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
